// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, frame bit indices,
// FSM state type, baud divider and frame-bit select helpers.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  localparam logic [3:0] START_IDX = 4'd0;
  localparam logic [3:0] STOP_IDX  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Clocks per bit, truncated.
  function automatic logic [31:0] baud_div(
    input logic [2:0]  code,
    input int unsigned clk_freq
  );
    int unsigned baud;
    baud = 9600;
    unique case (code)
      BAUD_9600:   baud = 9600;
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      BAUD_230400: baud = 230400;
      BAUD_460800: baud = 460800;
      BAUD_921600: baud = 921600;
    endcase
    return clk_freq / baud;
  endfunction

  // Line level for a given bit index of the frame.
  function automatic logic frame_bit(
    input logic [3:0] idx,
    input logic [7:0] data
  );
    logic       b;
    logic [3:0] k;
    b = 1'b1;
    k = idx - 4'd1;
    if (idx == START_IDX)
      b = 1'b0;
    else if (idx < STOP_IDX)
      b = data[k[2:0]];
    return b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..i_div-1 while enabled.
// Ports: i_en run/clear, i_div clocks per bit, o_tick at last count.
module uart_baud_gen
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [31:0] i_div,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic        w_tick;

  assign w_tick = i_en && (r_cnt == i_div - 32'd1);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!i_en || w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter, one byte per request, 3-bit baud code.
// Ports: byte_in/Buad_set/Send_en in, uart_tx line, Send_done pulse.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       Send_en,
  input  logic [2:0] Buad_set,
  output logic       uart_tx,
  output logic       Send_done
);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic [31:0] r_div;
  logic [31:0] w_div_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_tick;

  uart_baud_gen u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == SEND),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_div   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_div   <= w_div_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Line level is computed from the next bit index so the
  // registered output changes on the same edge as the index.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_div_nxt   = r_div;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (Send_en) begin
          w_state_nxt = SEND;
          w_idx_nxt   = START_IDX;
          w_data_nxt  = byte_in;
          w_div_nxt   = baud_div(Buad_set, CLK_FREQ);
          w_tx_nxt    = 1'b0;
        end
      end
      SEND: begin
        if (w_tick) begin
          if (r_idx == STOP_IDX) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = START_IDX;
            w_tx_nxt    = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
            w_tx_nxt  = frame_bit(r_idx + 4'd1, r_data);
          end
        end
      end
    endcase
  end

  assign uart_tx   = r_tx;
  assign Send_done = r_done;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte at 100 MHz:
// frame vectors, back-to-back, mid-frame changes, reset abort.
module tb_uart_tx_byte;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       Send_en = 1'b0;
  logic [2:0] Buad_set = 3'd0;
  logic       uart_tx;
  logic       Send_done;

  always #5 clk = ~clk;

  uart_tx_byte #(.CLK_FREQ(100_000_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .Send_en   (Send_en),
    .Buad_set  (Buad_set),
    .uart_tx   (uart_tx),
    .Send_done (Send_done)
  );

  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
    logic       hold;
    logic       chain;
    int         div;
    logic [9:0] frame;
  } vec_t;

  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  task automatic cmp(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [9:0] f);
    for (int i = 0; i < 10; i++)
      exp_q.push_back(f[i]);
  endtask

  // Called at the negedge where the request was driven.
  // Each bit must hold its level, with Send_done low, for div clocks.
  task automatic check_bits(input int div, input int nbits,
                            input logic drop_en,
                            input string tag);
    for (int b = 0; b < nbits; b++) begin
      logic e;
      logic ok;
      e  = exp_q.pop_front();
      ok = 1'b1;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0 && drop_en)
          Send_en = 1'b0;
        if (b == 5 && c == 0) begin
          byte_in  = ~byte_in;
          Buad_set = Buad_set ^ 3'd3;
        end
        if (uart_tx !== e || Send_done !== 1'b0)
          ok = 1'b0;
      end
      cmp($sformatf("%s bit%0d held=%0b", tag, b, e),
          {31'd0, ok}, 32'd1);
    end
  endtask

  initial begin
    tbl[0] = '{3'd4, 8'hAA, 1'b1, 1'b0, 868,
               {1'b1, 8'hAA, 1'b0}};
    tbl[1] = '{3'd4, 8'hAA, 1'b0, 1'b1, 868,
               {1'b1, 8'hAA, 1'b0}};
    tbl[2] = '{3'd5, 8'h3C, 1'b0, 1'b0, 434,
               {1'b1, 8'h3C, 1'b0}};
    tbl[3] = '{3'd6, 8'h81, 1'b0, 1'b0, 217,
               {1'b1, 8'h81, 1'b0}};
    tbl[4] = '{3'd7, 8'h5A, 1'b0, 1'b0, 108,
               {1'b1, 8'h5A, 1'b0}};

    repeat (20) @(negedge clk);
    cmp("reset tx", {31'd0, uart_tx}, 32'd1);
    cmp("reset done", {31'd0, Send_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("idle tx", {31'd0, uart_tx}, 32'd1);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (!tbl[v].chain)
        @(negedge clk);
      byte_in  = tbl[v].data;
      Buad_set = tbl[v].code;
      Send_en  = 1'b1;
      push_frame(tbl[v].frame);
      check_bits(tbl[v].div, 10, !tbl[v].hold, tag);
      @(negedge clk);
      cmp({tag, " done"}, {31'd0, Send_done}, 32'd1);
      cmp({tag, " gap tx"}, {31'd0, uart_tx}, 32'd1);
      if (!tbl[v].hold) begin
        @(negedge clk);
        cmp({tag, " done width"}, {31'd0, Send_done}, 32'd0);
        cmp({tag, " idle tx"}, {31'd0, uart_tx}, 32'd1);
      end
    end

    // 9600 baud: start and first two data bits, then abort.
    @(negedge clk);
    byte_in  = 8'h01;
    Buad_set = 3'd0;
    Send_en  = 1'b1;
    push_frame({1'b1, 8'h01, 1'b0});
    check_bits(10416, 3, 1'b1, "b9600");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("b9600 abort tx", {31'd0, uart_tx}, 32'd1);
    rst_n = 1'b1;

    // Reset during data bit 3 (a zero bit of 8'hF7).
    @(negedge clk);
    byte_in  = 8'hF7;
    Buad_set = 3'd6;
    Send_en  = 1'b1;
    push_frame({1'b1, 8'hF7, 1'b0});
    check_bits(217, 4, 1'b0, "rst");
    exp_q.delete();
    repeat (100) @(negedge clk);
    cmp("rst bit3 low", {31'd0, uart_tx}, 32'd0);
    rst_n   = 1'b0;
    Send_en = 1'b0;
    @(negedge clk);
    cmp("rst abort tx", {31'd0, uart_tx}, 32'd1);
    cmp("rst abort done", {31'd0, Send_done}, 32'd0);
    rst_n = 1'b1;
    begin
      logic ok;
      ok = 1'b1;
      repeat (2170) begin
        @(negedge clk);
        if (uart_tx !== 1'b1 || Send_done !== 1'b0)
          ok = 1'b0;
      end
      cmp("post abort quiet", {31'd0, ok}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
